// File: rtl/csa_pkg.sv
// Shared constants, FSM state type and sizing helper for the CSA operand loader.
// Optional build macro CSA_LOADER_CHKSUM_EN is consumed by csa_operand_loader.
package csa_pkg;

  localparam int CSA_W        = 26;
  localparam int CSA_N        = 29;
  localparam int CSA_TREE_LAT = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } csa_state_e;

  // Width needed to index n items; never returns less than 1.
  function automatic int csa_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_slot_bank.sv
// N x W operand register file: one indexed write port, bulk clear, and
// a clear of every slot above the write index (used when a short frame closes).
module csa_slot_bank
  import csa_pkg::*;
#(
  parameter int W  = CSA_W,
  parameter int N  = CSA_N,
  parameter int IW = csa_idx_w(CSA_N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [W-1:0]   wr_data,
  input  logic           clr_all,
  input  logic           clr_above,
  output logic [N*W-1:0] nums_o
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic [W-1:0] slot_reg;

      // Bulk clear wins over a write; the write wins over the above-index clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (clr_all) begin
          slot_reg <= '0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          slot_reg <= wr_data;
        end else if (clr_above && (IW'(gi) > wr_idx)) begin
          slot_reg <= '0;
        end
      end

      assign nums_o[gi*W +: W] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/csa_operand_loader.sv
// Serial-to-parallel feeder and result collector for the 29-operand CSA tree.
// Define CSA_LOADER_CHKSUM_EN to add a running-sum cross-check and the chk_err output.
module csa_operand_loader
  import csa_pkg::*;
#(
  parameter int W        = CSA_W,
  parameter int N        = CSA_N,
  parameter int TREE_LAT = CSA_TREE_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_last,
  output logic [N*W-1:0]                nums_o,
  input  logic [W-1:0]                  tree_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [W-1:0]                  res_data,
  output logic [csa_idx_w(N+1)-1:0]     res_cnt
`ifdef CSA_LOADER_CHKSUM_EN
  ,
  output logic                          chk_err
`endif
);

  localparam int IW = csa_idx_w(N);
  localparam int CW = csa_idx_w(N + 1);
  localparam int LW = csa_idx_w(TREE_LAT + 1);

  csa_state_e     state_reg;
  csa_state_e     state_next;
  logic [CW-1:0]  cnt_reg;
  logic [LW-1:0]  wait_reg;
  logic [W-1:0]   res_data_reg;
  logic [CW-1:0]  res_cnt_reg;

  logic accept;
  logic close_frame;
  logic capture;
  logic res_fire;
  logic wr_en;
  logic clr_all;
  logic clr_above;

  assign accept      = in_valid && in_ready;
  // The transfer into the last slot closes the frame regardless of in_last.
  assign close_frame = accept && (in_last || (cnt_reg == CW'(N - 1)));
  assign capture     = (state_reg == WAIT) && (wait_reg == LW'(1));
  assign res_fire    = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (close_frame) state_next = WAIT;
      WAIT:    if (capture)     state_next = OUT;
      OUT:     if (res_fire)    state_next = FILL;
      default:                  state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    wr_en     = 1'b0;
    clr_all   = 1'b0;
    clr_above = 1'b0;
    case (state_reg)
      FILL: begin
        in_ready  = 1'b1;
        wr_en     = accept;
        clr_above = close_frame;
      end
      OUT: begin
        res_valid = 1'b1;
        clr_all   = res_ready;
      end
      default: ;
    endcase
  end

  // Counters and the captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      wait_reg     <= '0;
      res_data_reg <= '0;
      res_cnt_reg  <= '0;
    end else begin
      if (res_fire) begin
        cnt_reg <= '0;
      end else if (accept) begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      if (close_frame) begin
        wait_reg <= LW'(TREE_LAT);
      end else if (state_reg == WAIT) begin
        wait_reg <= wait_reg - LW'(1);
      end

      if (capture) begin
        res_data_reg <= tree_result;
        res_cnt_reg  <= cnt_reg;
      end
    end
  end

  assign res_data = res_data_reg;
  assign res_cnt  = res_cnt_reg;

`ifdef CSA_LOADER_CHKSUM_EN
  logic [W-1:0] sum_reg;
  logic         chk_err_reg;

  // Independent running sum, compared against the tree at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      if (res_fire) begin
        sum_reg <= '0;
      end else if (accept) begin
        sum_reg <= sum_reg + in_data;
      end

      if (capture) begin
        chk_err_reg <= (sum_reg != tree_result);
      end else if (res_fire) begin
        chk_err_reg <= 1'b0;
      end
    end
  end

  assign chk_err = chk_err_reg;
`endif

  csa_slot_bank #(
    .W  (W),
    .N  (N),
    .IW (IW)
  ) u_slot_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (cnt_reg[IW-1:0]),
    .wr_data   (in_data),
    .clr_all   (clr_all),
    .clr_above (clr_above),
    .nums_o    (nums_o)
  );

endmodule

// File: doc/csa_operand_loader.md
Name: csa_operand_loader

Overview:
- Feeder and collector for the 29-operand carry-save sum tree (csa_2921).
- Accepts a serial stream of 26-bit operands over a valid/ready handshake and assembles them into one 29-operand frame.
- Holds the frame stable on the tree's parallel inputs while the tree's pipeline settles, captures the tree's result, and returns it over a valid/ready output handshake.
- This block is the serial-side counterpart of the parallel summation tree.

Parameters:
- W, 26, operand and result width in bits.
- N, 29, operands per frame.
- TREE_LAT, 2, clock cycles from stable tree inputs to a valid tree result.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds an operand.
- in_ready  output  1  loader can accept an operand.
- in_data  input  W  operand.
- in_last  input  1  marks the final operand of a short frame.
- nums_o  output  N*W  frame to the tree; slot k occupies bits [k*W +: W].
- tree_result  input  W  tree output.
- res_valid  output  1  res_data holds a frame sum.
- res_ready  input  1  downstream accepts res_data.
- res_data  output  W  captured sum, modulo 2^W.
- res_cnt  output  5  number of operands actually received in this frame (1..N).

Behaviour:
- Reset is asynchronous and active-high. While rst is high and on release:
  - state = FILL, slot counter = 0;
  - every nums_o slot = 0;
  - res_valid = 0, res_data = 0, res_cnt = 0;
  - in_ready = 1 on the first cycle after release.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready, write in_data to slot[cnt] and increment cnt.
  - The frame closes on a transfer that has in_last = 1, or on the transfer that fills slot N-1 (in_last is ignored there).
  - On close, every slot above the last written slot is set to 0 in the same edge. Slots are also cleared at the start of each frame, so no stale data from a previous frame survives.
  - When the frame closes, move to WAIT and load the wait counter with TREE_LAT.
  - No transfer = no state change.
- WAIT:
  - in_ready = 0; nums_o is held constant.
  - Decrement the wait counter each cycle.
  - On the cycle the counter reads 1, register tree_result into res_data and cnt into res_cnt, then move to OUT.
  - Total from the closing transfer edge to the capture edge is exactly TREE_LAT cycles.
- OUT:
  - res_valid = 1 and in_ready = 0.
  - res_data and res_cnt stay stable until res_valid & res_ready.
  - On that handshake: res_valid = 0, cnt = 0, all slots cleared, state = FILL.
  - Earliest restart: the next operand can be accepted on the cycle after the result handshake.
- Boundaries:
  - res_ready may be held high in advance; the result is then consumed on its first valid cycle.
  - An operand with in_last on slot 0 gives a one-operand frame with res_cnt = 1.
  - Reset mid-WAIT or mid-OUT aborts the frame and discards the result; no result is emitted.
  - A result is never dropped and never duplicated.
- Arithmetic: the sum wraps modulo 2^W. No overflow flag.

Optional Feature:
- Macro: CSA_LOADER_CHKSUM_EN.
- When defined:
  - a W-bit running sum of accepted operands is kept, reset to 0 at frame start;
  - at capture it is compared with tree_result;
  - extra output chk_err (1 bit) is valid with res_valid and is high on mismatch;
  - chk_err resets to 0.
- When undefined: no accumulator and no chk_err port; all other behaviour is identical.

Decomposition:
- Shared package csa_pkg holds:
  - constants CSA_W = 26, CSA_N = 29, CSA_TREE_LAT;
  - state enum FILL/WAIT/OUT;
  - the slot-index width function (clog2 of N).
- One natural sub-module: csa_slot_bank, the N×W register file with indexed write and bulk clear, driving nums_o.
- The FSM, counters and checksum logic stay in the top level.

Test Plan:
- Full frame: stream operands 1..29 back-to-back with res_ready = 1 and a tree model of latency 2 → res_data = 435, res_cnt = 29, res_valid rises exactly 2 cycles after the 29th transfer.
- Short frame: send 5, 7, 9 with in_last on 9 → nums_o slots 3..28 = 0, res_data = 21, res_cnt = 3.
- Wrap: send 29 operands of 0x3FFFFFF → res_data = 0x3FFFFE3 (-29 mod 2^26).
- Backpressure: hold res_ready = 0 for 10 cycles → res_valid and res_data stay stable and in_ready = 0 throughout; one result is consumed when res_ready rises.
- Reset mid-WAIT: assert rst one cycle after the frame closes → res_valid never rises, nums_o = 0, in_ready = 1 after release.
- With CSA_LOADER_CHKSUM_EN defined: corrupt the tree model's output by +1 → chk_err = 1; with a correct model → chk_err = 0.
